// File: rtl/button_event_ctrl.sv
// Debounced multi-button controller: synchronizes raw buttons, debounces on a
// prescaled tick, detects press/release/long-press and queues events in a FIFO.
module button_event_ctrl #(
   parameter int N_BTN      = 4,
   parameter int TICK_DIV   = 1000,
   parameter int DEB_TICKS  = 20,
   parameter int LONG_TICKS = 500,
   parameter int FIFO_DEPTH = 4,
   localparam int IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_state,
   output logic             o_evt_valid,
   input  logic             i_evt_ready,
   output logic [1:0]       o_evt_type,
   output logic [IDW-1:0]   o_evt_id,
   output logic             o_ovf,
   input  logic             i_ovf_clr
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(DEB_TICKS + 1);
   localparam int HW = $clog2(LONG_TICKS + 1);

   localparam logic [1:0] EVT_NONE  = 2'b00;
   localparam logic [1:0] EVT_PRESS = 2'b01;
   localparam logic [1:0] EVT_REL   = 2'b10;
   localparam logic [1:0] EVT_LONG  = 2'b11;

   logic [N_BTN-1:0] r_sync1, r_sync2, r_state;
   logic [TW-1:0]    r_presc;
   logic             w_tick;
   logic [DW-1:0]    r_deb  [N_BTN];
   logic [HW-1:0]    r_hold [N_BTN];
   logic [1:0]       r_new  [N_BTN];
   logic [1:0]       r_pend [N_BTN];
   logic [N_BTN-1:0] w_accept;

   logic [1:0]       r_fifo_type [FIFO_DEPTH];
   logic [IDW-1:0]   r_fifo_id   [FIFO_DEPTH];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_ovf;

   logic             w_sel_valid;
   logic [IDW-1:0]   w_sel_idx;
   logic [1:0]       w_sel_type;
   logic             w_full, w_push, w_pop, w_ovf_set;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_presc <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_presc <= w_tick ? '0 : r_presc + TW'(1);
      end
   end

   assign w_tick = (r_presc == TW'(TICK_DIV - 1));

   always_comb begin
      w_accept = '0;
      for (int i = 0; i < N_BTN; i++)
         w_accept[i] = w_tick && (r_sync2[i] != r_state[i]) && (r_deb[i] == DW'(DEB_TICKS - 1));
   end

   // A release on the same tick as the long threshold wins; the button is no longer held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            r_deb[i]  <= '0;
            r_hold[i] <= '0;
            r_new[i]  <= EVT_NONE;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            r_new[i] <= EVT_NONE;
            if (w_tick) begin
               if (w_accept[i]) begin
                  r_deb[i]   <= '0;
                  r_state[i] <= ~r_state[i];
                  r_new[i]   <= r_state[i] ? EVT_REL : EVT_PRESS;
               end else if (r_sync2[i] != r_state[i]) begin
                  r_deb[i] <= r_deb[i] + DW'(1);
               end else begin
                  r_deb[i] <= '0;
               end
            end
            if (w_accept[i] && !r_state[i]) begin
               r_hold[i] <= '0;
            end else if (w_tick && r_state[i] && (r_hold[i] != HW'(LONG_TICKS))) begin
               r_hold[i] <= r_hold[i] + HW'(1);
               if ((r_hold[i] == HW'(LONG_TICKS - 1)) && !w_accept[i])
                  r_new[i] <= EVT_LONG;
            end
         end
      end
   end

   // Lowest-index pending event wins the single FIFO slot per cycle.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_idx   = '0;
      w_sel_type  = EVT_NONE;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (r_pend[i] != EVT_NONE) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = IDW'(i);
            w_sel_type  = r_pend[i];
         end
      end
   end

   assign w_full = (r_count == CW'(FIFO_DEPTH));
   assign w_pop  = o_evt_valid && i_evt_ready;
   assign w_push = w_sel_valid && (!w_full || w_pop);

   always_comb begin
      w_ovf_set = 1'b0;
      for (int i = 0; i < N_BTN; i++)
         if ((r_new[i] != EVT_NONE) && (r_pend[i] != EVT_NONE) &&
             !(w_push && (w_sel_idx == IDW'(i))))
            w_ovf_set = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_BTN; i++) r_pend[i] <= EVT_NONE;
         r_ovf <= 1'b0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (r_new[i] != EVT_NONE)
               r_pend[i] <= r_new[i];
            else if (w_push && (w_sel_idx == IDW'(i)))
               r_pend[i] <= EVT_NONE;
         end
         r_ovf <= w_ovf_set | (r_ovf & ~i_ovf_clr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_type[i] <= EVT_NONE;
            r_fifo_id[i]   <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_fifo_type[r_wr_ptr] <= w_sel_type;
            r_fifo_id[r_wr_ptr]   <= w_sel_idx;
            r_wr_ptr              <= ptr_inc(r_wr_ptr);
         end
         if (w_pop)
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_state     = r_state;
   assign o_evt_valid = (r_count != '0);
   assign o_evt_type  = r_fifo_type[r_rd_ptr];
   assign o_evt_id    = r_fifo_id[r_rd_ptr];
   assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: popped events are collected into a queue
// and compared against hand-computed expected event lists.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_btn = '0;
  logic       i_evt_ready = 1'b0;
  logic       i_ovf_clr = 1'b0;
  logic [3:0] o_state;
  logic       o_evt_valid;
  logic [1:0] o_evt_type;
  logic [1:0] o_evt_id;
  logic       o_ovf;

  button_event_ctrl #(
    .N_BTN(4), .TICK_DIV(4), .DEB_TICKS(3), .LONG_TICKS(10), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn), .o_state(o_state),
    .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
    .o_evt_type(o_evt_type), .o_evt_id(o_evt_id),
    .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [3:0] got_q[$];
  int         got_t[$];
  logic [3:0] exp_q[$];
  logic       held_v = 1'b0;
  logic [3:0] held_e = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: records popped events and checks head stability under back-pressure.
  always @(negedge clk) begin
    if (!rst && o_evt_valid) begin
      if (held_v) check("head_stable", {28'd0, o_evt_type, o_evt_id}, {28'd0, held_e});
      if (i_evt_ready) begin
        got_q.push_back({o_evt_type, o_evt_id});
        got_t.push_back(cyc);
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held_e = {o_evt_type, o_evt_id};
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_btn = '0;
    i_evt_ready = 1'b0;
    i_ovf_clr = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    got_q.delete();
    got_t.delete();
  endtask

  task automatic check_events(input string tag);
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < got_q.size())
        check($sformatf("%s_evt%0d", tag, k), {28'd0, got_q[k]}, {28'd0, exp_q[k]});
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  initial begin
    // reset values
    do_reset();
    check("rst_state", o_state, 4'h0);
    check("rst_valid", o_evt_valid, 1'b0);
    check("rst_ovf", o_ovf, 1'b0);

    // single press on button 1
    i_evt_ready = 1'b1;
    i_btn[1] = 1'b1;
    idle(6);
    check("t31_early_state", o_state, 4'h0);
    idle(10);
    check("t31_state", o_state, 4'b0010);
    idle(16);
    exp_q.push_back({2'b01, 2'd1});
    check_events("t31");

    // bounce shorter than the debounce window
    do_reset();
    i_evt_ready = 1'b1;
    for (int k = 0; k < 34; k++) begin
      i_btn[0] = ~i_btn[0];
      idle(6);
      check("t32_state_bounce", o_state, 4'h0);
    end
    idle(20);
    check("t32_ovf", o_ovf, 1'b0);
    exp_q.delete();
    check_events("t32");

    // press, long-press, release on button 2
    do_reset();
    i_evt_ready = 1'b1;
    i_btn[2] = 1'b1;
    idle(60);
    i_btn[2] = 1'b0;
    idle(30);
    check("t33_state", o_state, 4'h0);
    if (got_t.size() >= 2) check("t33_long_delay", got_t[1] - got_t[0], 40);
    exp_q.push_back({2'b01, 2'd2});
    exp_q.push_back({2'b11, 2'd2});
    exp_q.push_back({2'b10, 2'd2});
    check_events("t33");

    // all pressed with consumer stalled, releases held pending
    do_reset();
    i_btn = 4'hF;
    idle(30);
    check("t34_state", o_state, 4'hF);
    check("t34_valid_full", o_evt_valid, 1'b1);
    check("t34_head", {o_evt_type, o_evt_id}, {2'b01, 2'd0});
    i_btn = 4'h0;
    idle(30);
    check("t34_state_rel", o_state, 4'h0);
    check("t34_ovf", o_ovf, 1'b0);
    check("t34_head_hold", {o_evt_type, o_evt_id}, {2'b01, 2'd0});
    i_evt_ready = 1'b1;
    idle(20);
    check("t34_drained", o_evt_valid, 1'b0);
    for (int b = 0; b < 4; b++) exp_q.push_back({2'b01, 2'(b)});
    for (int b = 0; b < 4; b++) exp_q.push_back({2'b10, 2'(b)});
    check_events("t34");

    // overflow on a pending press overwritten by its release, then clear
    do_reset();
    i_btn = 4'b1110;
    idle(20);
    i_btn = 4'b0000;
    idle(20);
    check("t35_ovf_none", o_ovf, 1'b0);
    i_btn[0] = 1'b1;
    idle(20);
    check("t35_ovf_press", o_ovf, 1'b0);
    i_btn[0] = 1'b0;
    idle(20);
    check("t35_ovf_set", o_ovf, 1'b1);
    i_ovf_clr = 1'b1;
    idle(1);
    i_ovf_clr = 1'b0;
    check("t35_ovf_clr", o_ovf, 1'b0);
    idle(3);
    check("t35_ovf_stays_clr", o_ovf, 1'b0);
    i_evt_ready = 1'b1;
    idle(20);
    exp_q.push_back({2'b01, 2'd1});
    exp_q.push_back({2'b01, 2'd2});
    exp_q.push_back({2'b01, 2'd3});
    exp_q.push_back({2'b10, 2'd1});
    exp_q.push_back({2'b10, 2'd0});
    exp_q.push_back({2'b10, 2'd2});
    exp_q.push_back({2'b10, 2'd3});
    check_events("t35");

    // asynchronous reset mid-debounce with events queued
    do_reset();
    i_btn = 4'b0011;
    idle(20);
    check("t36_valid_pre", o_evt_valid, 1'b1);
    check("t36_state_pre", o_state, 4'b0011);
    i_btn[2] = 1'b1;
    idle(5);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t36_async_state", o_state, 4'h0);
    check("t36_async_valid", o_evt_valid, 1'b0);
    check("t36_async_ovf", o_ovf, 1'b0);
    i_btn = 4'h0;
    i_evt_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(60);
    check("t36_state_post", o_state, 4'h0);
    check("t36_valid_post", o_evt_valid, 1'b0);
    exp_q.delete();
    check_events("t36");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 4, meaning number of button inputs (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 1000, meaning clk cycles per debounce tick (>=2).
REQ-003 SHALL have parameter DEB_TICKS, default 20, meaning consecutive differing ticks required to accept a level change (>=1).
REQ-004 SHALL have parameter LONG_TICKS, default 500, meaning ticks of accepted-pressed level before a long-press event (>DEB_TICKS).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of 2).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 i_btn  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-009 o_state  output  N_BTN  debounced levels.
REQ-010 o_evt_valid  output  1  FIFO head holds an event.
REQ-011 i_evt_ready  input  1  consumer accepts the head event.
REQ-012 o_evt_type  output  2  01 press, 10 release, 11 long-press (00 never valid).
REQ-013 o_evt_id  output  $clog2(N_BTN) (min 1)  button index of the head event.
REQ-014 o_ovf  output  1  sticky flag: an event was lost.
REQ-015 i_ovf_clr  input  1  synchronous clear of o_ovf.

Function
REQ-016 Each i_btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 A prescaler SHALL pulse an internal tick for one cycle every TICK_DIV cycles; the first tick occurs TICK_DIV cycles after reset release.
REQ-018 Per button, on each tick: synchronized level != o_state -> debounce counter increments; level == o_state -> counter clears to 0.
REQ-019 When the counter would reach DEB_TICKS, o_state SHALL toggle on that tick and the counter SHALL clear; a press (0->1) or release (1->0) event is raised.
REQ-020 Per button, a hold counter SHALL clear on each accepted press and increment on each tick while o_state=1, saturating at LONG_TICKS; reaching LONG_TICKS raises exactly one long-press event per press.
REQ-021 Raised events SHALL be stored in a per-button pending register (type, 2 bits), written in the cycle after the tick.
REQ-022 If an event is raised for a button whose pending register is non-zero, the new event SHALL overwrite it and o_ovf SHALL set.
REQ-023 An arbiter SHALL move at most one pending event per cycle into the FIFO, lowest button index first, only when the FIFO is not full; the moved pending register clears the same cycle.
REQ-024 Pending registers SHALL hold unchanged while the FIFO is full (back-pressure, no loss).
REQ-025 FIFO pop SHALL occur on o_evt_valid && i_evt_ready; o_evt_type/o_evt_id SHALL be stable while o_evt_valid=1 and i_evt_ready=0.
REQ-026 Simultaneous push and pop on a full FIFO SHALL both proceed; push into an empty FIFO makes o_evt_valid=1 on the following cycle.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH with a separate full/empty indication (no wasted entry).
REQ-028 i_ovf_clr=1 SHALL clear o_ovf unless a new overflow occurs the same cycle, in which case o_ovf stays 1.

Reset
REQ-029 On rst=1, immediately and independent of clk: o_state=0, o_evt_valid=0, o_ovf=0, synchronizers, prescaler, all counters, pending registers and FIFO pointers = 0.
REQ-030 Reset asserted mid-debounce or with FIFO non-empty SHALL discard all in-flight state; no event from before reset is ever emitted.

Verification (TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10, FIFO_DEPTH=4)
REQ-031 i_btn[1] held 1 for 16 cycles, ready=1 -> o_state[1]=1 after 3rd tick; single event type=01 id=1; no further event.
REQ-032 i_btn[0] toggling every 6 cycles for 200 cycles -> o_state[0] stays 0, no event, o_ovf=0.
REQ-033 i_btn[2] held 1 for 60 cycles then 0 -> events 01, 11 (10 ticks after press), 10, in that order, id=2.
REQ-034 i_btn[3:0] all pressed simultaneously, ready=0 -> 4 press events queued id 0,1,2,3; release with ready=0 -> releases held pending (FIFO full), o_ovf=0; then ready=1 -> 8 events drain in order.
REQ-035 ready=0, button 0 press then release while FIFO full and pending holds press -> o_ovf=1; i_ovf_clr pulse -> o_ovf=0.
REQ-036 rst pulsed between clk edges during debounce with 2 events queued -> outputs 0 immediately; after release, no stale events.
